// File: rtl/fir_mac_scheduler_if.sv
// Stream and config bundle for the time-multiplexed FIR controller.
// The master is the sample source / coefficient writer / result sink. The slave is the filter.
interface fir_mac_scheduler_if #(
   parameter int unsigned AW = 2,
   parameter int unsigned DW = 8,
   parameter int unsigned CW = 8,
   parameter int unsigned OW = 18
);

   // Input sample stream
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;

   // Output result stream
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;

   // Coefficient write port
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [CW-1:0] cfg_data;
   logic          cfg_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready,
      output cfg_we,
      output cfg_addr,
      output cfg_data,
      input  cfg_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready,
      input  cfg_we,
      input  cfg_addr,
      input  cfg_data,
      output cfg_ready
   );

endinterface

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR controller: one shared MAC swept over N taps per accepted sample.
// Owns the sample delay line and the coefficient file. Results leave on a valid/ready stream
// and are held until taken.
module fir_mac_scheduler #(
   parameter int unsigned N  = 4,
   parameter int unsigned AW = 2,
   parameter int unsigned DW = 8,
   parameter int unsigned CW = 8,
   parameter int unsigned OW = 18
) (
   input  logic                  clk,
   input  logic                  reset,
   fir_mac_scheduler_if.slave    bus,
   output logic                  busy
);

   localparam int unsigned PW = DW + CW;
   localparam logic [AW-1:0] LastTap = AW'(N - 1);
   localparam logic [AW:0]   NumTaps = (AW + 1)'(N);

   typedef enum logic [1:0] {
      StIdle,
      StMac,
      StOut
   } state_e;

   state_e        state_q;
   logic [DW-1:0] x_q     [N];
   logic [CW-1:0] coeff_q [N];
   logic [OW-1:0] acc_q;
   logic [AW-1:0] tap_q;
   logic          out_valid_q;
   logic [OW-1:0] out_data_q;

   logic [PW-1:0] prod;
   logic [OW-1:0] sum;
   logic          idle;
   logic          cfg_take;

   // Current tap product and running sum; the sum wraps modulo 2**OW.
   always_comb begin
      prod = PW'(x_q[tap_q]) * PW'(coeff_q[tap_q]);
      sum  = acc_q + OW'(prod);
   end

   // Handshake readiness depends only on registered state.
   always_comb begin
      idle     = (state_q == StIdle);
      // Out-of-range addresses are silently dropped.
      cfg_take = bus.cfg_we && idle && ({1'b0, bus.cfg_addr} < NumTaps);
   end

   // Sequencer, delay line and coefficient file.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         tap_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int unsigned k = 0; k < N; k++) begin
            x_q[k]     <= '0;
            coeff_q[k] <= CW'(k + 1);
         end
      end else begin
         // A write landing on the accept edge is seen by that sample's MAC sweep.
         if (cfg_take) begin
            coeff_q[bus.cfg_addr] <= bus.cfg_data;
         end

         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  for (int unsigned k = N - 1; k > 0; k--) begin
                     x_q[k] <= x_q[k-1];
                  end
                  x_q[0]  <= bus.in_data;
                  acc_q   <= '0;
                  tap_q   <= '0;
                  state_q <= StMac;
               end
            end
            StMac: begin
               acc_q <= sum;
               tap_q <= tap_q + AW'(1);
               if (tap_q == LastTap) begin
                  out_data_q  <= sum;
                  out_valid_q <= 1'b1;
                  tap_q       <= '0;
                  state_q     <= StOut;
               end
            end
            StOut: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.in_ready  = idle;
   assign bus.cfg_ready = idle;
   assign busy          = !idle;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // The result flag is only ever raised together with the OUT state.
   a_valid_matches_state: assert property (@(posedge clk) out_valid_q == (state_q == StOut));

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
Time-multiplexed FIR controller. It sequences one shared multiply-accumulate unit over N taps per input sample, owns the sample delay line and the coefficient register file, and exposes valid/ready streams on input and output. A config port allows coefficient rewrites between samples. It sits between the sample source and downstream logic, replacing a fully parallel N-multiplier filter where area matters more than throughput.

Parameters:
N, 4, number of taps (>=2)
AW, 2, coefficient address width; N <= 2**AW
DW, 8, input sample width, unsigned
CW, 8, coefficient width, unsigned
OW, 18, output/accumulator width; result is modulo 2**OW

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  sample present
in_ready  out  1  block can accept a sample
in_data  in  DW  sample value
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
out_data  out  OW  filter output y
cfg_we  in  1  coefficient write request
cfg_addr  in  AW  coefficient index
cfg_data  in  CW  coefficient value
cfg_ready  out  1  coefficient write will be taken this cycle
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, delay line x[0..N-1]=0, acc=0, tap=0, out_valid=0, out_data=0, coeff[k]=(k+1) truncated to CW. Reset overrides every other input, including mid-MAC and a stalled OUT. The partial result is discarded.
- States: IDLE, MAC, OUT. in_ready=(state==IDLE), cfg_ready=(state==IDLE), busy=(state!=IDLE). These are decoded from registered state only, with no combinational path from in_valid or out_ready.
- IDLE, on in_valid&&in_ready: x[k]<=x[k-1] for k=N-1..1, x[0]<=in_data, acc<=0, tap<=0, then go to MAC.
- MAC, one product per cycle: acc<=acc+x[tap]*coeff[tap] (unsigned, zero-extended, wraps modulo 2**OW), tap<=tap+1. On the cycle that processes tap==N-1: out_data<=final sum, out_valid<=1, go to OUT. MAC lasts exactly N cycles.
- OUT: out_valid=1. out_data is held stable until out_valid&&out_ready. On that handshake, out_valid<=0 and the state goes to IDLE.
- Latency: sample accepted at edge E gives out_valid=1 after edge E+N. Minimum sample period is N+2 cycles (accept, N MACs, output handshake).
- Config write: if cfg_we&&cfg_ready, coeff[cfg_addr]<=cfg_data. If cfg_addr>=N, the write is ignored.
  - cfg_we while cfg_ready==0 is dropped, not queued. The master holds the request until cfg_ready.
  - A config write and a sample accept on the same edge are both performed. The new coefficient applies to that sample.
- No sample is accepted during MAC or OUT. Upstream holds in_data/in_valid.
- The delay line is updated only on accept. A stalled OUT state does not shift samples.

Test Plan:
1. Defaults (coeff=1,2,3,4) after reset, stream 10,20,30,40 with out_ready=1 -> out_data 10, 40, 100, 200. Each out_valid rises N=4 edges after its accept. Accepts are spaced exactly 6 cycles apart.
2. Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid=1 and out_data unchanged throughout. in_ready=0 and cfg_ready=0. An in_valid pulse of value 99 is not accepted and the delay line is unchanged. Releasing out_ready gives in_ready=1 on the next cycle.
3. Config/accept collision: after reset, same edge cfg_we (addr 0, data 5) and in_valid with data 2 -> out_data=10. Then cfg_we (addr 1, data 9) asserted only during MAC -> ignored. The next sample 1 yields 1*5+2*2=9.
4. Width boundary: write all coeff=255, feed four samples of 255 -> outputs 65025, 130050, 195075, 260100 (0x3F804). No wrap at OW=18.
5. Reset mid-operation: assert reset during the third MAC cycle -> the next cycle shows state IDLE, in_ready=1, out_valid=0, coefficients back to 1..4. The next sample 7 gives out_data=7, proving the delay line was cleared.
